vfu_response_router: RTL
========================

# vfu_response_router

Sits at the VFU end of the slot-to-VFU request path: it gates each slot's requests into the VFU on a per-slot credit count and steers VFU responses back to the issuing slot by tag. VFU responses carry no backpressure. The router therefore holds a credit per free buffer entry and admits a request only when its slot has an entry reserved. It instances once per VFU, between the per-VFU request arbiter and the VFU, with four slot-side response ports.

## Interface
- DEPTH, 2, response buffer entries per slot; also initial credit count per slot (1..4)
- DATA_W, 32, response data width
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clock
- io_reqIn_valid  in  1  request from arbiter output
- io_reqIn_ready  out  1  request accepted
- io_reqIn_tag  in  2  issuing slot index
- io_reqOut_valid  out  1  request presented to VFU
- io_reqOut_ready  in  1  VFU can take request
- io_vfuResp_valid  in  1  VFU response valid (no ready)
- io_vfuResp_tag  in  2  destination slot
- io_vfuResp_data  in  DATA_W  result
- io_vfuResp_executeIndex  in  2  sub-element index
- io_vfuResp_vxsat  in  1  saturation flag
- io_slotResp_i_valid  out  1  response to slot i, i = 0..3
- io_slotResp_i_ready  in  1  slot i consumes
- io_slotResp_i_data  out  DATA_W
- io_slotResp_i_executeIndex  out  2
- io_slotResp_i_vxsat  out  1
- io_overflow  out  1  sticky error: response hit a full buffer

## Operation
- Per slot t:
  - credit[t], width clog2(DEPTH+1), reset value DEPTH
  - FIFO[t] of DEPTH entries {data, executeIndex, vxsat}, in-order
- Request gating (combinational):
  - io_reqOut_valid = io_reqIn_valid & (credit[tag] != 0)
  - io_reqIn_ready = io_reqOut_ready & (credit[tag] != 0)
  - Request fire = io_reqIn_valid & io_reqIn_ready.
- Credit update, per slot, same cycle:
  - request fire for t: −1
  - slot t dequeue (io_slotResp_t_valid & ready): +1
  - both in the same cycle: unchanged
  - Credit never exceeds DEPTH and never goes below 0.
- Response enqueue: io_vfuResp_valid writes FIFO[tag] at its tail.
- FIFO full and no same-cycle dequeue on that slot:
  - the response is dropped
  - io_overflow is set and held until reset
  - no credit change
- Full FIFO with a same-cycle dequeue on that slot: enqueue succeeds.
- io_slotResp_t_valid = FIFO[t] non-empty. Outputs show the head entry; they hold stable while valid & !ready.
- The four slots are fully independent; simultaneous dequeues on all slots are legal.

## Timing
- Reset (reset low at edge):
  - credits = DEPTH, all FIFOs empty
  - all io_slotResp_i_valid = 0, io_overflow = 0
  - io_reqOut_valid follows io_reqIn_valid, since credits are nonzero.
- Reset mid-operation: in-flight VFU responses are discarded; a response arriving in the reset cycle is not stored.
- Request path: zero latency, purely combinational gating; no registers.
- Response path, default: a response enqueued at edge N is visible as io_slotResp_t_valid after edge N, i.e. 1 cycle of latency.
- Credit returned by a dequeue at edge N is usable by a request in the cycle after edge N.
- Wrap-around: FIFO pointers are modulo DEPTH; full and empty are distinguished by an occupancy count per slot.

## Configuration
- VFU_RESP_BYPASS_EN
  - Defined: when FIFO[t] is empty and io_vfuResp_valid targets t, the response appears combinationally on io_slotResp_t_* in the same cycle.
    - If io_slotResp_t_ready is high, the response is consumed without enqueue and credit[t] increments at that edge.
    - Otherwise it enqueues normally.
  - Undefined: always 1-cycle latency through the FIFO; no combinational path from io_vfuResp_* to io_slotResp_*.

## Test plan
- Reset, then io_reqIn_valid=1 tag=2 with io_reqOut_ready=1 for 3 cycles, DEPTH=2, no responses -> 2 fires, then io_reqIn_ready=0 and io_reqOut_valid=0 on cycle 3; credit[2]=0.
- Two requests on tag 1, then VFU responses data 0xA, 0xB, tag 1, with slot 1 ready low -> slot 1 presents 0xA, stable; raising ready yields 0xA then 0xB in order; credit[1] returns to 2.
- Request fire and slot 0 dequeue in the same cycle, tag 0 -> credit[0] unchanged.
- Force a response to a full FIFO[3] with ready low -> response dropped, io_overflow=1 and held until reset; with ready high the same cycle -> accepted, io_overflow stays 0.
- Reset asserted while FIFO[0] holds 1 entry and a response is arriving -> next cycle valid=0 on all slots, credits=2.
- VFU_RESP_BYPASS_EN defined, empty FIFO[1], slot 1 ready, response data 0x5 -> io_slotResp_1_data=0x5, valid=1 in the same cycle; undefined -> appears 1 cycle later.

Source files
------------

// File: rtl/vfu_response_router_if.sv
// Slot/VFU-side signal bundle for vfu_response_router.
// master: arbiter, VFU and slots; slave: the router.
interface vfu_response_router_if #(
  parameter int DATA_W = 32
);
  logic              io_reqIn_valid;
  logic              io_reqIn_ready;
  logic [1:0]        io_reqIn_tag;
  logic              io_reqOut_valid;
  logic              io_reqOut_ready;
  logic              io_vfuResp_valid;
  logic [1:0]        io_vfuResp_tag;
  logic [DATA_W-1:0] io_vfuResp_data;
  logic [1:0]        io_vfuResp_executeIndex;
  logic              io_vfuResp_vxsat;
  logic              io_slotResp_0_valid;
  logic              io_slotResp_0_ready;
  logic [DATA_W-1:0] io_slotResp_0_data;
  logic [1:0]        io_slotResp_0_executeIndex;
  logic              io_slotResp_0_vxsat;
  logic              io_slotResp_1_valid;
  logic              io_slotResp_1_ready;
  logic [DATA_W-1:0] io_slotResp_1_data;
  logic [1:0]        io_slotResp_1_executeIndex;
  logic              io_slotResp_1_vxsat;
  logic              io_slotResp_2_valid;
  logic              io_slotResp_2_ready;
  logic [DATA_W-1:0] io_slotResp_2_data;
  logic [1:0]        io_slotResp_2_executeIndex;
  logic              io_slotResp_2_vxsat;
  logic              io_slotResp_3_valid;
  logic              io_slotResp_3_ready;
  logic [DATA_W-1:0] io_slotResp_3_data;
  logic [1:0]        io_slotResp_3_executeIndex;
  logic              io_slotResp_3_vxsat;
  logic              io_overflow;

  modport master (
    output io_reqIn_valid, io_reqIn_tag, io_reqOut_ready,
    output io_vfuResp_valid, io_vfuResp_tag, io_vfuResp_data,
    output io_vfuResp_executeIndex, io_vfuResp_vxsat,
    output io_slotResp_0_ready, io_slotResp_1_ready,
    output io_slotResp_2_ready, io_slotResp_3_ready,
    input  io_reqIn_ready, io_reqOut_valid,
    input  io_slotResp_0_valid, io_slotResp_0_data,
    input  io_slotResp_0_executeIndex, io_slotResp_0_vxsat,
    input  io_slotResp_1_valid, io_slotResp_1_data,
    input  io_slotResp_1_executeIndex, io_slotResp_1_vxsat,
    input  io_slotResp_2_valid, io_slotResp_2_data,
    input  io_slotResp_2_executeIndex, io_slotResp_2_vxsat,
    input  io_slotResp_3_valid, io_slotResp_3_data,
    input  io_slotResp_3_executeIndex, io_slotResp_3_vxsat,
    input  io_overflow
  );

  modport slave (
    input  io_reqIn_valid, io_reqIn_tag, io_reqOut_ready,
    input  io_vfuResp_valid, io_vfuResp_tag, io_vfuResp_data,
    input  io_vfuResp_executeIndex, io_vfuResp_vxsat,
    input  io_slotResp_0_ready, io_slotResp_1_ready,
    input  io_slotResp_2_ready, io_slotResp_3_ready,
    output io_reqIn_ready, io_reqOut_valid,
    output io_slotResp_0_valid, io_slotResp_0_data,
    output io_slotResp_0_executeIndex, io_slotResp_0_vxsat,
    output io_slotResp_1_valid, io_slotResp_1_data,
    output io_slotResp_1_executeIndex, io_slotResp_1_vxsat,
    output io_slotResp_2_valid, io_slotResp_2_data,
    output io_slotResp_2_executeIndex, io_slotResp_2_vxsat,
    output io_slotResp_3_valid, io_slotResp_3_data,
    output io_slotResp_3_executeIndex, io_slotResp_3_vxsat,
    output io_overflow
  );
endinterface

// File: rtl/vfu_response_router.sv
// Credit-gated VFU request path and per-slot response FIFOs.
// VFU_RESP_BYPASS_EN: empty-FIFO responses pass through same cycle.
module vfu_response_router #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32
) (
  input logic clock,
  input logic reset,
  vfu_response_router_if.slave io
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [1:0]        eidx;
    logic              vxsat;
  } ent_t;

  ent_t          mem_q [4][DEPTH];
  logic [PW-1:0] rd_q [4];
  logic [PW-1:0] rd_d [4];
  logic [PW-1:0] wr_q [4];
  logic [PW-1:0] wr_d [4];
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];
  logic [CW-1:0] cred_q [4];
  logic [CW-1:0] cred_d [4];
  logic          ovf_q, ovf_d;

  logic [3:0] rdy, hit, fire, deq;
  logic [3:0] push, pop, byp, drop, sval;
  ent_t       vin;
  ent_t       shown [4];
  logic       cred_ok;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign rdy = {io.io_slotResp_3_ready,
                io.io_slotResp_2_ready,
                io.io_slotResp_1_ready,
                io.io_slotResp_0_ready};

  assign vin = '{data:  io.io_vfuResp_data,
                 eidx:  io.io_vfuResp_executeIndex,
                 vxsat: io.io_vfuResp_vxsat};

  assign cred_ok = (cred_q[io.io_reqIn_tag] != '0);
  assign io.io_reqOut_valid = io.io_reqIn_valid & cred_ok;
  assign io.io_reqIn_ready  = io.io_reqOut_ready & cred_ok;

  always_comb begin
    hit  = '0;
    fire = '0;
    byp  = '0;
    sval = '0;
    deq  = '0;
    pop  = '0;
    push = '0;
    drop = '0;
    for (int t = 0; t < 4; t++) begin
      hit[t]  = io.io_vfuResp_valid
              & (io.io_vfuResp_tag == 2'(t));
      fire[t] = io.io_reqIn_valid & io.io_reqIn_ready
              & (io.io_reqIn_tag == 2'(t));
`ifdef VFU_RESP_BYPASS_EN
      byp[t]   = hit[t] & (cnt_q[t] == '0);
      sval[t]  = (cnt_q[t] != '0) | byp[t];
      shown[t] = byp[t] ? vin : mem_q[t][rd_q[t]];
`else
      sval[t]  = (cnt_q[t] != '0);
      shown[t] = mem_q[t][rd_q[t]];
`endif
      deq[t]  = sval[t] & rdy[t];
      pop[t]  = deq[t] & (cnt_q[t] != '0);
      // a full FIFO can still accept when its head leaves this edge
      push[t] = hit[t] & ((cnt_q[t] != CW'(DEPTH)) | pop[t])
              & ~(byp[t] & rdy[t]);
      drop[t] = hit[t] & (cnt_q[t] == CW'(DEPTH)) & ~pop[t];
    end
  end

  always_comb begin
    ovf_d = ovf_q | (|drop);
    for (int t = 0; t < 4; t++) begin
      cnt_d[t]  = cnt_q[t] + CW'(push[t]) - CW'(pop[t]);
      cred_d[t] = cred_q[t] + CW'(deq[t]) - CW'(fire[t]);
      rd_d[t]   = pop[t] ? inc(rd_q[t]) : rd_q[t];
      wr_d[t]   = push[t] ? inc(wr_q[t]) : wr_q[t];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      ovf_q <= 1'b0;
      for (int t = 0; t < 4; t++) begin
        cnt_q[t]  <= '0;
        cred_q[t] <= CW'(DEPTH);
        rd_q[t]   <= '0;
        wr_q[t]   <= '0;
      end
    end else begin
      ovf_q <= ovf_d;
      for (int t = 0; t < 4; t++) begin
        cnt_q[t]  <= cnt_d[t];
        cred_q[t] <= cred_d[t];
        rd_q[t]   <= rd_d[t];
        wr_q[t]   <= wr_d[t];
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int t = 0; t < 4; t++) begin
      if (push[t]) mem_q[t][wr_q[t]] <= vin;
    end
  end

  assign io.io_overflow = ovf_q;

  assign io.io_slotResp_0_valid        = sval[0];
  assign io.io_slotResp_0_data         = shown[0].data;
  assign io.io_slotResp_0_executeIndex = shown[0].eidx;
  assign io.io_slotResp_0_vxsat        = shown[0].vxsat;
  assign io.io_slotResp_1_valid        = sval[1];
  assign io.io_slotResp_1_data         = shown[1].data;
  assign io.io_slotResp_1_executeIndex = shown[1].eidx;
  assign io.io_slotResp_1_vxsat        = shown[1].vxsat;
  assign io.io_slotResp_2_valid        = sval[2];
  assign io.io_slotResp_2_data         = shown[2].data;
  assign io.io_slotResp_2_executeIndex = shown[2].eidx;
  assign io.io_slotResp_2_vxsat        = shown[2].vxsat;
  assign io.io_slotResp_3_valid        = sval[3];
  assign io.io_slotResp_3_data         = shown[3].data;
  assign io.io_slotResp_3_executeIndex = shown[3].eidx;
  assign io.io_slotResp_3_vxsat        = shown[3].vxsat;
endmodule
